// File: rtl/ram_port_arbiter_if.sv
// Requester-side command/response bus of the RAM port arbiter.
// The master modport is the client side; the slave modport is the arbiter side.
interface ram_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_wr;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata,
        input  gnt, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata,
        output gnt, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with
// per-read owner tracking so read data returns to the requester that issued it.
module ram_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave bus,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    win_id;
    logic               win_found;
    logic               win_valid;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [DATA_W-1:0]  rdata_hold;
    rd_tag_t            rd_pipe [RD_LAT];

    // First valid requester at or after ptr, wrapping around.
    // NOTE: every output of this block is assigned a default up front so no path leaves it unassigned (no latch).
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int idx;
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!win_found && bus.req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    assign win_valid = win_found && rst_n;

    always_comb begin
        gnt = '0;
        if (win_valid) gnt[win_id] = 1'b1;
    end

    assign bus.gnt       = gnt;
    assign bus.rsp_valid = rsp_valid;
    // Read data comes straight from the RAM in the response cycle and is held afterwards.
    assign bus.rsp_rdata = (|rsp_valid) ? mem_dout : rdata_hold;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr      <= '0;
            mem_en   <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            mem_en <= win_valid;
            mem_wr <= win_valid && bus.req_wr[win_id];
            if (win_valid) begin
                ptr      <= (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
                mem_addr <= bus.req_addr[win_id*ADDR_W +: ADDR_W];
                mem_din  <= bus.req_wdata[win_id*DATA_W +: DATA_W];
            end
        end
    end

    // Owner tags follow each read through the RAM; the last stage is rsp_valid itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
            rsp_valid  <= '0;
            rdata_hold <= '0;
        end else begin
            rd_pipe[0] <= '{valid: win_valid && !bus.req_wr[win_id], id: win_id};
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
            rsp_valid <= rd_pipe[RD_LAT-1].valid ? (NUM_REQ'(1) << rd_pipe[RD_LAT-1].id) : '0;
            if (|rsp_valid) rdata_hold <= mem_dout;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM
// (registered read data, one cycle latency) attached to the shared port.
module tb_ram_port_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int RD_LAT  = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] ram [2**ADDR_W];

    int n_assert = 0;
    int n_fail   = 0;

    ram_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) ram[mem_addr] <= mem_din;
            else        mem_dout      <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic w, input int a, input int d);
        bus.req_valid[i]                  = v;
        bus.req_wr[i]                     = w;
        bus.req_addr[i*ADDR_W +: ADDR_W]  = ADDR_W'(a);
        bus.req_wdata[i*DATA_W +: DATA_W] = DATA_W'(d);
    endtask

    task automatic clear_all();
        bus.req_valid = '0;
    endtask

    // Drive point of a new cycle, then the sample point 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;
        mem_dout      = '0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 10 + i, 'h10 + i);

        // 1: reset with all requesters active
        next_cycle(); settle();
        check("rst_gnt",       32'(bus.gnt), 0);
        check("rst_mem_en",    32'(mem_en), 0);
        check("rst_mem_wr",    32'(mem_wr), 0);
        check("rst_mem_addr",  32'(mem_addr), 0);
        check("rst_mem_din",   32'(mem_din), 0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        check("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        next_cycle(); settle();
        check("rst_gnt2", 32'(bus.gnt), 0);
        next_cycle(); rst_n = 1'b1; settle();
        check("first_gnt", 32'(bus.gnt), 'b0001);
        next_cycle(); clear_all(); settle();
        check("first_gnt_idle", 32'(bus.gnt), 0);
        check("first_mem_en",   32'(mem_en), 1);
        check("first_mem_wr",   32'(mem_wr), 1);
        check("first_mem_addr", 32'(mem_addr), 10);
        check("first_mem_din",  32'(mem_din), 'h10);

        // 2: req2 write 0xA5 to addr 5, then read it back (ptr=1)
        next_cycle(); set_req(2, 1'b1, 1'b1, 5, 'hA5); settle();
        check("t2_wr_gnt", 32'(bus.gnt), 'b0100);
        check("t2_idle_en", 32'(mem_en), 0);
        check("t2_idle_wr", 32'(mem_wr), 0);
        check("t2_idle_addr_hold", 32'(mem_addr), 10);
        next_cycle(); set_req(2, 1'b1, 1'b0, 5, 'hA5); settle();
        check("t2_rd_gnt",   32'(bus.gnt), 'b0100);
        check("t2_mem_wr",   32'(mem_wr), 1);
        check("t2_mem_addr", 32'(mem_addr), 5);
        check("t2_mem_din",  32'(mem_din), 'hA5);
        next_cycle(); clear_all(); settle();
        check("t2_rd_en",     32'(mem_en), 1);
        check("t2_rd_wr",     32'(mem_wr), 0);
        check("t2_rsp_early", 32'(bus.rsp_valid), 0);
        next_cycle(); settle();
        check("t2_rsp_valid", 32'(bus.rsp_valid), 'b0100);
        check("t2_rsp_rdata", 32'(bus.rsp_rdata), 'hA5);
        check("t2_en_off",    32'(mem_en), 0);
        next_cycle(); settle();
        check("t2_rsp_one",   32'(bus.rsp_valid), 0);
        check("t2_rdata_hold", 32'(bus.rsp_rdata), 'hA5);

        // req3 alone (ptr=3) moves ptr to 0 for the rotation test
        next_cycle(); set_req(3, 1'b1, 1'b1, 63, 'h77); settle();
        check("pre3_gnt", 32'(bus.gnt), 'b1000);

        // 3: all four requesters continuously active for 8 cycles
        for (int j = 0; j < 8; j++) begin
            next_cycle();
            for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b1, 20 + i, 'h20 + i);
            settle();
            check($sformatf("t3_gnt_%0d", j), 32'(bus.gnt), 32'(1) << (j % 4));
            check($sformatf("t3_en_%0d", j),  32'(mem_en), 1);
            if (j > 0) check($sformatf("t3_addr_%0d", j), 32'(mem_addr), 20 + ((j - 1) % 4));
        end
        next_cycle(); clear_all(); settle();
        check("t3_tail_en",   32'(mem_en), 1);
        check("t3_tail_addr", 32'(mem_addr), 23);

        // 4: grant to req1 (ptr=0 -> 2), then req1 and req3 contend
        next_cycle(); set_req(1, 1'b1, 1'b1, 30, 'h31); settle();
        check("t4_gnt1", 32'(bus.gnt), 'b0010);
        next_cycle(); set_req(1, 1'b1, 1'b1, 31, 'h41); set_req(3, 1'b1, 1'b1, 33, 'h43); settle();
        check("t4_gnt3_first", 32'(bus.gnt), 'b1000);
        next_cycle(); set_req(3, 1'b0, 1'b1, 33, 'h43); settle();
        check("t4_gnt1_second", 32'(bus.gnt), 'b0010);
        check("t4_addr3", 32'(mem_addr), 33);
        next_cycle(); clear_all(); settle();
        check("t4_addr1", 32'(mem_addr), 31);
        check("t4_din1",  32'(mem_din), 'h41);

        // 5: req0 writes 0x3C to addr 3, req1 reads addr 3 right after (ptr=2)
        next_cycle(); set_req(0, 1'b1, 1'b1, 3, 'h3C); settle();
        check("t5_wr_gnt", 32'(bus.gnt), 'b0001);
        next_cycle(); set_req(0, 1'b0, 1'b1, 3, 'h3C); set_req(1, 1'b1, 1'b0, 3, 0); settle();
        check("t5_rd_gnt", 32'(bus.gnt), 'b0010);
        check("t5_mem_wr", 32'(mem_wr), 1);
        next_cycle(); clear_all(); settle();
        check("t5_rd_addr", 32'(mem_addr), 3);
        check("t5_rd_wr",   32'(mem_wr), 0);
        next_cycle(); settle();
        check("t5_rsp_valid", 32'(bus.rsp_valid), 'b0010);
        check("t5_rsp_rdata", 32'(bus.rsp_rdata), 'h3C);

        // 6: req2 read granted (ptr=2), reset in the following cycle
        next_cycle(); set_req(2, 1'b1, 1'b0, 5, 0); settle();
        check("t6_rd_gnt", 32'(bus.gnt), 'b0100);
        next_cycle(); clear_all(); set_req(0, 1'b1, 1'b1, 1, 1); rst_n = 1'b0; settle();
        check("t6_gnt_in_rst", 32'(bus.gnt), 0);
        check("t6_cmd_en",     32'(mem_en), 1);
        next_cycle(); clear_all(); rst_n = 1'b1; settle();
        check("t6_en_after",   32'(mem_en), 0);
        check("t6_addr_after", 32'(mem_addr), 0);
        check("t6_rsp_0",      32'(bus.rsp_valid), 0);
        for (int j = 1; j < 4; j++) begin
            next_cycle(); settle();
            check($sformatf("t6_rsp_%0d", j), 32'(bus.rsp_valid), 0);
        end
        next_cycle(); set_req(3, 1'b1, 1'b1, 2, 2); set_req(1, 1'b1, 1'b1, 2, 2); settle();
        check("t6_ptr_reset", 32'(bus.gnt), 'b0010);
        next_cycle(); clear_all(); settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Round-robin arbiter that shares a single port of the dual_port_RAM (port A or B) between NUM_REQ independent requesters. It accepts read/write commands with a valid/grant handshake and issues at most one RAM access per cycle. It tracks which requester owns each in-flight read and routes read data back to that requester with fixed latency. Sits between client blocks and one RAM port; the other RAM port stays free for an independent agent.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 6, RAM address width
DATA_W, 8, RAM data width
RD_LAT, 1, cycles from address sampled by the RAM to valid mem_dout (1..3)

Ports:
clk  in  1  single clock; also drives the shared RAM port clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester command valid
req_wr  in  NUM_REQ  per-requester 1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing
gnt  out  NUM_REQ  one-hot command accept, combinational
rsp_valid  out  NUM_REQ  one-hot read-data valid, registered
rsp_rdata  out  DATA_W  read data, qualified by rsp_valid
mem_en  out  1  RAM access this cycle
mem_wr  out  1  RAM write strobe, to RAM wr
mem_addr  out  ADDR_W  to RAM addr
mem_din  out  DATA_W  to RAM din
mem_dout  in  DATA_W  from RAM dout

Behaviour:
- Reset (rst_n low at posedge): ptr=0, mem_en=0, mem_wr=0, mem_addr=0, mem_din=0, rsp_valid=0, rsp_rdata=0, all read-tracking stages invalid. gnt=0 while rst_n low.
- Arbitration (cycle N): scan req_valid from index ptr upward, wrapping. The first set bit k wins. gnt[k]=1 in the same cycle. No request gives gnt=0.
- A requester holds req_valid/req_wr/req_addr/req_wdata stable until it sees gnt. Deasserting before gnt is allowed; that command is then withdrawn.
- Pointer: after a grant to k, ptr <= (k+1) mod NUM_REQ. With no grant, ptr holds. Guarantees each active requester at least one grant per NUM_REQ cycles.
- Command stage: on the posedge ending cycle N, register mem_en=1, mem_wr=req_wr[k], mem_addr, mem_din. These are presented to the RAM during cycle N+1.
- Idle cycle: mem_en=0 and mem_wr=0. mem_addr and mem_din hold their previous values.
- Throughput: one grant per cycle, back-to-back, with no bubbles.
- Read tracking: a shift pipeline of depth 1+RD_LAT carries {valid, owner id}; it is only loaded for reads.
- Read response: rsp_valid[k]=1 in cycle N+1+RD_LAT for exactly one cycle. rsp_rdata equals mem_dout sampled for that access; default RD_LAT=1 gives rsp in cycle N+2. rsp_rdata holds when rsp_valid=0.
- Writes generate no response; mem_wr is high for exactly one cycle (N+1).
- Read-after-write to the same address from any requesters in consecutive grants returns the new data, because the write completes at the end of N+1, before the read address is sampled.
- Reset mid-operation: all in-flight reads are discarded and no rsp_valid follows. Requesters must reissue.
- Out-of-range owner ids are impossible; no error output.

Test Plan:
1. rst_n=0 for 2 cycles with all req_valid=1 -> gnt=0, mem_en=0, rsp_valid=0; the first grant after release goes to requester 0.
2. Req2 writes addr 5 data 0xA5, then req2 reads addr 5 -> mem_wr=1 addr 5 din 0xA5 one cycle after the write gnt; rsp_valid=4'b0100 with rsp_rdata=0xA5 two cycles after the read gnt.
3. All four req_valid held high for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3 one-hot, one per cycle, mem_en continuously 1.
4. After a grant to req1 (ptr=2), req1 and req3 both valid -> req3 granted first, then req1.
5. Req0 writes addr 3 data 0x3C; req1 reads addr 3 in the next cycle -> rsp_valid[1] with 0x3C, no stall.
6. Req2 read granted, rst_n=0 in the following cycle -> no rsp_valid at any point; mem_en=0 after reset.
